// File: rtl/param_mem_pkg.sv
// param_mem shared types and constants.
// State encoding and legal read-latency range.
package param_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic bit lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/param_mem_rd_pipe.sv
// param_mem read-latency pipeline.
// Valid shifts every cycle; data advances only with valid.
module param_mem_rd_pipe
  import param_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [RD_LAT-1:0] v_q;
  logic [DATA_W-1:0] d_q [RD_LAT];

  // Shift valids; each data stage loads only behind a valid,
  // so the last stage holds the most recent read result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < RD_LAT; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= valid_i;
      if (valid_i) d_q[0] <= data_i;
      for (int i = 1; i < RD_LAT; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end
  end

  assign valid_o = v_q[RD_LAT-1];
  assign data_o  = d_q[RD_LAT-1];

endmodule

// File: rtl/param_mem.sv
// param_mem: byte-enabled single-port memory, RD_LAT read latency.
// Optional power-up clear sweep: define PARAM_MEM_CLEAR_EN.
module param_mem
  import param_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic                  ready,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rvalid,
  output logic                  drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  if ((DATA_W % 8) != 0 || !lat_ok(RD_LAT)) begin : g_bad_cfg
    $error("param_mem: illegal DATA_W or RD_LAT");
  end

  state_e            state_q, state_d;
  logic              drop_q, drop_d;
  logic              acc, wr, rd;
  logic [DATA_W-1:0] mem [DEPTH];

`ifdef PARAM_MEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_q, clr_d;
`endif

  assign ready  = (state_q == RUN);
  assign acc    = req & ready;
  assign wr     = acc & we;
  assign rd     = acc & ~we;
  assign drop_d = req & ~ready;
  assign drop   = drop_q;

  // Next state: CLEAR either sweeps the array or exits at once.
  always_comb begin
    state_d = state_q;
`ifdef PARAM_MEM_CLEAR_EN
    clr_d = clr_q;
`endif
    case (state_q)
      CLEAR: begin
`ifdef PARAM_MEM_CLEAR_EN
        clr_d = clr_q + 1'b1;
        if (&clr_q) state_d = RUN;
`else
        state_d = RUN;
`endif
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // Control registers; reset restarts any sweep from word 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      drop_q  <= 1'b0;
`ifdef PARAM_MEM_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
`ifdef PARAM_MEM_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  // Storage is never reset; sweep and writes are exclusive.
  always_ff @(posedge clk) begin
`ifdef PARAM_MEM_CLEAR_EN
    if (!reset && state_q == CLEAR) mem[clr_q] <= '0;
`endif
    if (wr) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  param_mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .valid_i (rd),
    .data_i  (mem[addr]),
    .valid_o (rvalid),
    .data_o  (rdata)
  );

endmodule
